// File: rtl/instruction_fetch_unit.sv
// Fetch-stage controller: issues instruction-memory requests at the current PC,
// computes the next PC, and hands a registered instruction bundle to decode.
module instruction_fetch_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_INCR    = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] PCResult,
    output logic [DATA_WIDTH-1:0] Address,
    output logic                  IMemReq,
    output logic [DATA_WIDTH-1:0] IMemAddr,
    input  logic                  IMemReady,
    input  logic [DATA_WIDTH-1:0] IMemData,
    input  logic                  Stall,
    input  logic                  Redirect,
    input  logic [DATA_WIDTH-1:0] RedirectTarget,
    output logic [DATA_WIDTH-1:0] IF_Instruction,
    output logic [DATA_WIDTH-1:0] IF_PCPlus4,
    output logic                  IF_Valid,
    output logic [1:0]            debug_fetch_state
);

    localparam logic [1:0] S_REQ   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(PC_INCR);

    logic [1:0]            state_reg, state_next;
    logic [DATA_WIDTH-1:0] held_instr_reg, held_instr_next;
    logic [DATA_WIDTH-1:0] held_pcp4_reg, held_pcp4_next;
    logic [DATA_WIDTH-1:0] target_reg, target_next;
    logic [DATA_WIDTH-1:0] if_instr_reg, if_instr_next;
    logic [DATA_WIDTH-1:0] if_pcp4_reg, if_pcp4_next;
    logic                  if_valid_reg, if_valid_next;
    logic [DATA_WIDTH-1:0] next_pc;
    logic                  mem_req;
    logic [DATA_WIDTH-1:0] pc_plus_incr;

    // Wraps modulo 2^DATA_WIDTH by construction.
    assign pc_plus_incr = PCResult + PC_STEP;

    always_comb begin
        state_next      = state_reg;
        held_instr_next = held_instr_reg;
        held_pcp4_next  = held_pcp4_reg;
        target_next     = target_reg;
        if_instr_next   = if_instr_reg;
        if_pcp4_next    = if_pcp4_reg;
        if_valid_next   = if_valid_reg;
        mem_req         = 1'b0;
        next_pc         = PCResult;

        if (Reset) begin
            // Drive the PC register to 0 so the first post-reset fetch is at 0.
            next_pc = '0;
            mem_req = 1'b0;
        end else begin
            case (state_reg)
                S_REQ: begin
                    mem_req = 1'b1;
                    if (IMemReady) begin
                        if (Redirect) begin
                            next_pc       = RedirectTarget;
                            if_valid_next = 1'b0;
                        end else begin
                            next_pc = pc_plus_incr;
                            if (!Stall) begin
                                if_instr_next = IMemData;
                                if_pcp4_next  = pc_plus_incr;
                                if_valid_next = 1'b1;
                            end else begin
                                held_instr_next = IMemData;
                                held_pcp4_next  = pc_plus_incr;
                                state_next      = S_HOLD;
                            end
                        end
                    end else if (Redirect) begin
                        // Request still in flight: keep the address stable and drain it.
                        target_next   = RedirectTarget;
                        if_valid_next = 1'b0;
                        state_next    = S_DRAIN;
                    end else if (!Stall) begin
                        if_valid_next = 1'b0;
                    end
                end

                S_HOLD: begin
                    if (Redirect) begin
                        next_pc       = RedirectTarget;
                        if_valid_next = 1'b0;
                        state_next    = S_REQ;
                    end else if (!Stall) begin
                        if_instr_next = held_instr_reg;
                        if_pcp4_next  = held_pcp4_reg;
                        if_valid_next = 1'b1;
                        state_next    = S_REQ;
                    end
                end

                S_DRAIN: begin
                    mem_req       = 1'b1;
                    if_valid_next = 1'b0;
                    if (IMemReady) begin
                        // A redirect arriving with the response is the most recent one.
                        next_pc    = Redirect ? RedirectTarget : target_reg;
                        state_next = S_REQ;
                    end else if (Redirect) begin
                        target_next = RedirectTarget;
                    end
                end

                default: begin
                    state_next = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= S_REQ;
            held_instr_reg <= '0;
            held_pcp4_reg  <= '0;
            target_reg     <= '0;
            if_instr_reg   <= '0;
            if_pcp4_reg    <= '0;
            if_valid_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            held_instr_reg <= held_instr_next;
            held_pcp4_reg  <= held_pcp4_next;
            target_reg     <= target_next;
            if_instr_reg   <= if_instr_next;
            if_pcp4_reg    <= if_pcp4_next;
            if_valid_reg   <= if_valid_next;
        end
    end

    assign Address           = next_pc;
    assign IMemReq           = mem_req;
    assign IMemAddr          = PCResult;
    assign IF_Instruction    = if_instr_reg;
    assign IF_PCPlus4        = if_pcp4_reg;
    assign IF_Valid          = if_valid_reg;
    assign debug_fetch_state = state_reg;

endmodule
